// File: rtl/lane_select_encoder.sv
// Purpose: places a tagged 32-bit word on one of four lanes for HOLD cycles, then GUARD all-zero cycles.
// Latency: lanes show the word on the cycle after the accepting edge; all outputs are registered.
// Backpressure: in_ready is high only in IDLE; requests seen while busy are ignored, not errored.
module lane_select_encoder #(
    parameter int HOLD  = 4,
    parameter int GUARD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_idx,
    input  logic [31:0] in_data,
    output logic [31:0] A1,
    output logic [31:0] A2,
    output logic [31:0] A3,
    output logic [31:0] A4,
    output logic        frame_active,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    // Counters are loaded with "cycles remaining minus one" so a zero count marks the final cycle.
    localparam logic [3:0] HOLD_M1  = 4'(HOLD - 1);
    localparam logic [3:0] GUARD_M1 = 4'(GUARD - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [31:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d, a4_q, a4_d;
    logic        frame_active_q, frame_active_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Ready is a pure decode of the state register, so it never depends on the request inputs.
    assign in_ready     = (state_q == S_IDLE);
    assign A1           = a1_q;
    assign A2           = a2_q;
    assign A3           = a3_q;
    assign A4           = a4_q;
    assign frame_active = frame_active_q;
    assign done         = done_q;
    assign err          = err_q;

    // Next-state, counter and output decode; outputs are computed from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // A zero tag is invisible to the downstream decoder, so refuse it outright.
                    if (in_data[4:0] != 5'd0) begin
                        idx_d   = in_idx;
                        data_d  = in_data;
                        cnt_d   = HOLD_M1;
                        state_d = S_DRIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = GUARD_M1;
                    state_d = S_GUARD;
                    // With a single guard cycle the first guard cycle is also the last one.
                    done_d  = (GUARD_M1 == 4'd0);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GUARD: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    done_d = (cnt_q == 4'd1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        frame_active_d = (state_d == S_DRIVE);
        a1_d = 32'h0;
        a2_d = 32'h0;
        a3_d = 32'h0;
        a4_d = 32'h0;
        if (state_d == S_DRIVE) begin
            case (idx_d)
                2'd0:    a1_d = data_d;
                2'd1:    a2_d = data_d;
                2'd2:    a3_d = data_d;
                default: a4_d = data_d;
            endcase
        end
    end

    // State and output registers; reset wins over any frame or guard in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            idx_q          <= 2'd0;
            data_q         <= 32'h0;
            a1_q           <= 32'h0;
            a2_q           <= 32'h0;
            a3_q           <= 32'h0;
            a4_q           <= 32'h0;
            frame_active_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            a1_q           <= a1_d;
            a2_q           <= a2_d;
            a3_q           <= a3_d;
            a4_q           <= a4_d;
            frame_active_q <= frame_active_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

endmodule

// File: tb/tb_lane_select_encoder.sv
// Purpose: directed checks of lane_select_encoder with default (4,1) and corner (1,3) timing parameters.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: a request held across a busy frame must be taken only once in_ready returns.
module tb_lane_select_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        vld [2];
    logic [1:0]  idx [2];
    logic [31:0] dat [2];
    logic        rdy [2];
    logic        fa  [2];
    logic        dn  [2];
    logic        er  [2];
    logic [31:0] la  [2][4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start [4];

    always @(posedge clk) cyc <= cyc + 1;

    lane_select_encoder #(.HOLD(4), .GUARD(1)) u_dflt (
        .clk(clk), .rst(rst[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_idx(idx[0]), .in_data(dat[0]),
        .A1(la[0][0]), .A2(la[0][1]), .A3(la[0][2]), .A4(la[0][3]),
        .frame_active(fa[0]), .done(dn[0]), .err(er[0])
    );

    lane_select_encoder #(.HOLD(1), .GUARD(3)) u_corner (
        .clk(clk), .rst(rst[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_idx(idx[1]), .in_data(dat[1]),
        .A1(la[1][0]), .A2(la[1][1]), .A3(la[1][2]), .A4(la[1][3]),
        .frame_active(fa[1]), .done(dn[1]), .err(er[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lane = -1 means every lane must be zero.
    task automatic chk_state(input int u, input string tag, input int lane, input logic [31:0] d,
                             input logic fa_e, input logic dn_e, input logic er_e, input logic rdy_e);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_u%0d_A%0d", tag, u, i + 1), la[u][i], (i == lane) ? d : 32'h0);
        chk($sformatf("%s_u%0d_frame_active", tag, u), {31'h0, fa[u]}, {31'h0, fa_e});
        chk($sformatf("%s_u%0d_done", tag, u), {31'h0, dn[u]}, {31'h0, dn_e});
        chk($sformatf("%s_u%0d_err", tag, u), {31'h0, er[u]}, {31'h0, er_e});
        chk($sformatf("%s_u%0d_in_ready", tag, u), {31'h0, rdy[u]}, {31'h0, rdy_e});
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1;
            vld[u] = 1'b0;
            idx[u] = 2'd0;
            dat[u] = 32'h0;
        end

        // Reset held for two edges, then idle
        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_state(0, "reset", -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_state(1, "reset", -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Basic frame on A3: four drive cycles, one guard cycle with done, then ready
        vld[0] = 1'b1; idx[0] = 2'd2; dat[0] = 32'h0000_0013;
        tick();
        vld[0] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk_state(0, $sformatf("basic_c%0d", c), 2, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk_state(0, "basic_guard", -1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state(0, "basic_idle", -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Zero tag is rejected with a single err pulse
        vld[0] = 1'b1; idx[0] = 2'd1; dat[0] = 32'hFFFF_FFE0;
        tick();
        vld[0] = 1'b0;
        chk_state(0, "reject", -1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_state(0, "reject_after", -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: a second request appears during the first frame and waits
        vld[0] = 1'b1; idx[0] = 2'd3; dat[0] = 32'h0000_0021;
        tick();
        idx[0] = 2'd0; dat[0] = 32'h0000_0001;
        for (int c = 1; c <= 4; c++) begin
            chk_state(0, $sformatf("bp_first_c%0d", c), 3, 32'h0000_0021, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk_state(0, "bp_guard", -1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state(0, "bp_idle", -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        vld[0] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk_state(0, $sformatf("bp_second_c%0d", c), 0, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk_state(0, "bp_second_guard", -1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset during the second drive cycle of an A4 frame
        vld[0] = 1'b1; idx[0] = 2'd3; dat[0] = 32'h0000_0101;
        tick();
        vld[0] = 1'b0;
        chk_state(0, "mid_c1", 3, 32'h0000_0101, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk_state(0, "mid_reset", -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk_state(0, $sformatf("mid_after_c%0d", c), -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // HOLD=1, GUARD=3: back-to-back requests across all four lanes
        for (int k = 0; k < 4; k++) begin
            vld[1] = 1'b1; idx[1] = 2'(k); dat[1] = 32'h0000_001F;
            tick();
            start[k] = cyc;
            if (k > 0)
                chk($sformatf("corner_spacing_%0d", k), 32'(start[k] - start[k-1]), 32'd5);
            chk_state(1, $sformatf("corner%0d_drive", k), k, 32'h0000_001F, 1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 3)
                vld[1] = 1'b0;
            tick();
            chk_state(1, $sformatf("corner%0d_g1", k), -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            chk_state(1, $sformatf("corner%0d_g2", k), -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            chk_state(1, $sformatf("corner%0d_g3", k), -1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            chk_state(1, $sformatf("corner%0d_idle", k), -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
